axicb_cpl_router: RTL and testbench

Completion-channel router for one crossbar master port. It tracks outstanding requests per ID in parametrised per-ID queues and arbitrates the slaves' read or write completions fairly across IDs. It keeps each granted burst locked until its last beat, checks read-burst length and watches for stalled completions. It sits between the master-side address-channel decoder and the completion mux.

---
 rtl/axicb_cpl_router_pkg.sv | 22 ++
 rtl/axicb_cpl_router_if.sv | 31 +++
 rtl/axicb_round_robin_core.sv | 40 ++++
 rtl/axicb_scfifo.sv | 50 +++++
 rtl/axicb_cpl_router.sv | 175 +++++++++++++++++
 tb/tb_axicb_cpl_router.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/axicb_cpl_router_pkg.sv
// Shared types and helpers for the completion router.
//   cpl_state_e : router FSM states
//   entry_w     : width of one queued request entry
//   id_to_q     : maps an AXI ID to its per-ID queue index
package axicb_cpl_pkg;

  localparam int LEN_W = 8;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} cpl_state_e;

  // Entry layout, LSB first: id, mr, ix, then len on the read path only.
  function automatic int entry_w(input int rd_path, input int slv_nb, input int id_w);
    return LEN_W * rd_path + slv_nb + 1 + id_w;
  endfunction

  // Only the low log2(id_nb) bits of the result matter; callers truncate.
  function automatic logic [31:0] id_to_q(input logic [31:0] id, input logic [31:0] mask,
                                          input int id_nb);
    return (id ^ mask) & 32'(id_nb - 1);
  endfunction

endpackage

// File: rtl/axicb_cpl_router_if.sv
// Address-side push and completion-side grant signals of the completion router.
//   slave  : router side (takes pushes and slave completions, drives grant/head)
//   master : surrounding crossbar side
interface axicb_cpl_router_if
  import axicb_cpl_pkg::*;
#(
  parameter int AXI_ID_W = 8,
  parameter int SLV_NB   = 4,
  parameter int CCH_W    = 8
);
  logic                    a_valid, a_ready, a_full, a_mr;
  logic [LEN_W-1:0]        a_len;
  logic [AXI_ID_W-1:0]     a_id;
  logic [SLV_NB-1:0]       a_ix;

  logic [SLV_NB-1:0]       c_grant, c_ix, c_valid, c_last;
  logic                    c_mr, c_ready;
  logic [LEN_W-1:0]        c_len;
  logic [AXI_ID_W-1:0]     c_id;
  logic [CCH_W*SLV_NB-1:0] c_ch;

  modport slave (
    input  a_valid, a_ready, a_len, a_id, a_ix, a_mr, c_valid, c_last, c_ready, c_ch,
    output a_full, c_grant, c_mr, c_len, c_id, c_ix
  );

  modport master (
    output a_valid, a_ready, a_len, a_id, a_ix, a_mr, c_valid, c_last, c_ready, c_ch,
    input  a_full, c_grant, c_mr, c_len, c_id, c_ix
  );
endinterface

// File: rtl/axicb_round_robin_core.sv
// Round-robin arbiter core.
//   req      : request vector
//   gidx     : index of the first requester at or after the priority pointer
//   gvld     : some request is present
//   en       : move priority to the slot after rot_idx
module axicb_round_robin_core #(
  parameter  int REQ_NB = 4,
  localparam int IW     = $clog2(REQ_NB)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              en,
  input  logic [IW-1:0]     rot_idx,
  input  logic [REQ_NB-1:0] req,
  output logic [IW-1:0]     gidx,
  output logic              gvld
);
  logic [IW-1:0] ptr, idx;

  // REQ_NB is a power of two, so the index wraps naturally.
  always_comb begin
    gidx = '0;
    gvld = 1'b0;
    idx  = '0;
    for (int k = 0; k < REQ_NB; k++) begin
      idx = ptr + IW'(k);
      if (!gvld && req[idx]) begin
        gidx = idx;
        gvld = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  ptr <= '0;
    else if (srst) ptr <= '0;
    else if (en)   ptr <= rot_idx + IW'(1);
  end
endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock show-ahead FIFO on a register file.
//   push/data_in  : write side; a push while full is dropped
//   pull/data_out : read side; data_out always shows the head entry
//   full/empty    : occupancy flags
module axicb_scfifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pull,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full from empty when the addresses match.
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  do_push, do_pull;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign do_push = push & ~full;
  assign do_pull = pull & ~empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
      if (do_pull) rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
endmodule

// File: rtl/axicb_cpl_router.sv
// Completion router for one crossbar master port.
//   aclk/aresetn/srst : clock, async low reset, sync high reset
//   bus (slave)       : request push side and completion grant side
//   c_beat            : beat index inside the active burst
//   c_err_len         : registered pulse on a read length mismatch
//   c_timeout         : sticky watchdog flag
//   ostd_cnt          : outstanding requests across all ID queues
module axicb_cpl_router
  import axicb_cpl_pkg::*;
#(
  parameter int                  RD_PATH     = 0,
  parameter int                  AXI_ID_W    = 8,
  parameter int                  SLV_NB      = 4,
  parameter int                  ID_NB       = 4,
  parameter int                  ID_DEPTH    = 4,
  parameter logic [AXI_ID_W-1:0] MST_ID_MASK = '0,
  parameter int                  CCH_W       = 8,
  parameter int                  TIMEOUT_W   = 12,
  localparam int                 OW          = $clog2(ID_NB*ID_DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  axicb_cpl_router_if.slave bus,
  output logic [LEN_W-1:0] c_beat,
  output logic             c_err_len,
  output logic             c_timeout,
  output logic [OW-1:0]    ostd_cnt
);
  localparam int QW     = $clog2(ID_NB);
  localparam int EW     = entry_w(RD_PATH, SLV_NB, AXI_ID_W);
  localparam int IX_LSB = AXI_ID_W + 1;

  logic [QW-1:0]                   push_q, gidx, lock, sel;
  logic                            push_en, push_ok, any_req, sel_vld;
  logic                            hs, last, hs_last, err_d;
  logic [EW-1:0]                   push_data;
  logic [ID_NB-1:0]                q_full, q_empty, q_push, q_pull, req, head_mr;
  logic [ID_NB-1:0][EW-1:0]        head;
  logic [ID_NB-1:0][SLV_NB-1:0]    head_ix;
  logic [ID_NB-1:0][LEN_W-1:0]     head_len;
  logic [SLV_NB-1:0][QW-1:0]       slv_q;
  cpl_state_e                      state, state_nxt;

  // ---- push side ----
  assign push_q     = QW'(id_to_q(32'(bus.a_id), 32'(MST_ID_MASK), ID_NB));
  assign push_en    = bus.a_valid & bus.a_ready;
  assign push_ok    = push_en & ~q_full[push_q];
  assign bus.a_full = q_full[push_q];

  if (RD_PATH != 0) begin : g_rd_pack
    assign push_data = {bus.a_len, bus.a_ix, bus.a_mr, bus.a_id};
  end else begin : g_wr_pack
    logic unused_len;
    assign unused_len = ^bus.a_len;
    assign push_data  = {bus.a_ix, bus.a_mr, bus.a_id};
  end

  // Queue index of the ID each slave is currently presenting.
  for (genvar j = 0; j < SLV_NB; j++) begin : g_slv
    assign slv_q[j] = QW'(id_to_q(32'(bus.c_ch[j*CCH_W +: AXI_ID_W]), 32'(MST_ID_MASK), ID_NB));
  end
  // Payload bits above the ID only matter to the completion mux.
  logic unused_ch;
  assign unused_ch = ^bus.c_ch;

  // ---- per-ID queues ----
  for (genvar i = 0; i < ID_NB; i++) begin : g_q
    logic [SLV_NB-1:0] hit;

    assign q_push[i] = push_en & (push_q == QW'(i));
    assign q_pull[i] = hs_last & (sel == QW'(i));

    axicb_scfifo #(.DATA_WIDTH(EW), .ADDR_WIDTH($clog2(ID_DEPTH))) u_fifo (
      .aclk, .aresetn, .srst,
      .push(q_push[i]), .data_in(push_data),
      .pull(q_pull[i]), .data_out(head[i]),
      .full(q_full[i]), .empty(q_empty[i])
    );

    assign head_mr[i] = head[i][AXI_ID_W];
    assign head_ix[i] = head[i][IX_LSB +: SLV_NB];
    if (RD_PATH != 0) begin : g_len
      assign head_len[i] = head[i][EW-1 -: LEN_W];
    end else begin : g_nolen
      assign head_len[i] = '0;
    end

    // A slave only counts if it is the head's target and carries this queue's ID.
    for (genvar j = 0; j < SLV_NB; j++) begin : g_hit
      assign hit[j] = bus.c_valid[j] & head_ix[i][j] & (slv_q[j] == QW'(i));
    end
    assign req[i] = ~q_empty[i] & (head_mr[i] | (|hit));
  end

  // ---- arbitration ----
  axicb_round_robin_core #(.REQ_NB(ID_NB)) u_rr (
    .aclk, .aresetn, .srst,
    .en(hs_last), .rot_idx(sel),
    .req(req), .gidx(gidx), .gvld(any_req)
  );

  assign sel     = (state == BURST) ? lock : gidx;
  assign sel_vld = (state == BURST) | any_req;
  assign hs      = bus.c_ready & sel_vld & req[sel];
  // A misrouted head is always a single local beat on either path.
  assign last    = head_mr[sel] | (|(bus.c_last & head_ix[sel]));
  assign hs_last = hs & last;

  assign err_d = (RD_PATH != 0) && hs &&
                 (last ? (c_beat != head_len[sel]) : (c_beat == head_len[sel]));

  assign bus.c_grant = sel_vld ? head_ix[sel] : '0;
  assign bus.c_ix    = bus.c_grant;
  assign bus.c_mr    = sel_vld & head_mr[sel];
  assign bus.c_len   = sel_vld ? head_len[sel] : '0;
  assign bus.c_id    = sel_vld ? head[sel][AXI_ID_W-1:0] : '0;

  // ---- FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs && !last) state_nxt = BURST;
      BURST: if (hs_last)     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      lock      <= '0;
      c_beat    <= '0;
      c_err_len <= 1'b0;
      ostd_cnt  <= '0;
    end else if (srst) begin
      state     <= IDLE;
      lock      <= '0;
      c_beat    <= '0;
      c_err_len <= 1'b0;
      ostd_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      if (state == IDLE && hs && !last) lock <= gidx;
      if (hs_last) c_beat <= '0;
      else if (hs) c_beat <= c_beat + LEN_W'(1);
      c_err_len <= err_d;
      ostd_cnt  <= ostd_cnt + OW'(push_ok) - OW'(hs_last);
    end
  end

  // ---- watchdog ----
  if (TIMEOUT_W > 0) begin : g_wd
    logic [TIMEOUT_W-1:0] wd;
    logic                 to_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        wd   <= '0;
        to_q <= 1'b0;
      end else if (srst) begin
        wd   <= '0;
        to_q <= 1'b0;
      end else if (hs) begin
        wd <= '0;
      end else if (ostd_cnt != '0 && wd != '1) begin
        wd <= wd + TIMEOUT_W'(1);
        // Flag together with the step that reaches all-ones.
        if (&(wd | TIMEOUT_W'(1))) to_q <= 1'b1;
      end
    end
    assign c_timeout = to_q;
  end else begin : g_nowd
    assign c_timeout = 1'b0;
  end
endmodule

// File: tb/tb_axicb_cpl_router.sv
module tb_axicb_cpl_router;
  logic       aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
  logic [7:0] c_beat;
  logic       c_err_len, c_timeout;
  logic [4:0] ostd_cnt;
  int         n_chk = 0, n_fail = 0;

  always #5 aclk = ~aclk;

  axicb_cpl_router_if #(.AXI_ID_W(8), .SLV_NB(4), .CCH_W(8)) bus ();

  axicb_cpl_router #(
    .RD_PATH(1), .AXI_ID_W(8), .SLV_NB(4), .ID_NB(4), .ID_DEPTH(4),
    .MST_ID_MASK(8'h00), .CCH_W(8), .TIMEOUT_W(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus),
    .c_beat(c_beat), .c_err_len(c_err_len), .c_timeout(c_timeout), .ostd_cnt(ostd_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [3:0] ix, input logic [7:0] len,
                      input logic mr);
    bus.a_valid = 1'b1; bus.a_ready = 1'b1;
    bus.a_id = id; bus.a_ix = ix; bus.a_len = len; bus.a_mr = mr;
    tick();
    bus.a_valid = 1'b0;
  endtask

  task automatic slv(input int j, input logic v, input logic l, input logic [7:0] id);
    bus.c_valid[j] = v;
    bus.c_last[j]  = l;
    bus.c_ch[j*8 +: 8] = id;
  endtask

  task automatic cidle();
    bus.c_valid = '0;
    bus.c_last  = '0;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_ready = 0; bus.a_len = 0; bus.a_id = 0; bus.a_ix = 0; bus.a_mr = 0;
    bus.c_valid = 0; bus.c_last = 0; bus.c_ready = 0; bus.c_ch = '0;

    // reset state
    repeat (3) tick();
    settle();
    chk("rst_grant", bus.c_grant, 0);
    chk("rst_afull", bus.a_full, 0);
    chk("rst_ostd", ostd_cnt, 0);
    chk("rst_beat", c_beat, 0);
    chk("rst_err", c_err_len, 0);
    chk("rst_timeout", c_timeout, 0);
    aresetn = 1'b1;
    tick();

    // 4-beat burst, ID 1 to slave 2, len 3
    push(8'd1, 4'b0100, 8'd3, 1'b0);
    settle();
    chk("t1_ostd_push", ostd_cnt, 1);
    chk("t1_nogrant", bus.c_grant, 0);
    bus.c_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      slv(2, 1'b1, b == 3, 8'd1);
      settle();
      chk("t1_grant", bus.c_grant, 4'b0100);
      chk("t1_beat", c_beat, b);
      if (b == 0) begin
        chk("t1_len", bus.c_len, 3);
        chk("t1_id", bus.c_id, 1);
      end
      tick();
    end
    cidle();
    settle();
    chk("t1_ostd_pull", ostd_cnt, 0);
    chk("t1_beat_clr", c_beat, 0);
    chk("t1_no_err", c_err_len, 0);
    chk("t1_idle_grant", bus.c_grant, 0);

    // alternating single-beat grants between queues 0 and 1
    push(8'd0, 4'b0001, 8'd0, 1'b0);
    push(8'd0, 4'b0001, 8'd0, 1'b0);
    push(8'd1, 4'b0010, 8'd0, 1'b0);
    push(8'd1, 4'b0010, 8'd0, 1'b0);
    settle();
    chk("t2_ostd", ostd_cnt, 4);
    slv(0, 1'b1, 1'b1, 8'd0);
    slv(1, 1'b1, 1'b1, 8'd1);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_alt", bus.c_grant, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      tick();
    end
    settle();
    chk("t2_empty_grant", bus.c_grant, 0);
    chk("t2_ostd_0", ostd_cnt, 0);

    // queue 0 burst holds the grant while queue 1 waits
    cidle();
    push(8'd0, 4'b0001, 8'd2, 1'b0);
    push(8'd1, 4'b0010, 8'd0, 1'b0);
    slv(0, 1'b1, 1'b0, 8'd0);
    slv(1, 1'b1, 1'b1, 8'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) slv(0, 1'b1, 1'b1, 8'd0);
      settle();
      chk("t2_burst_hold", bus.c_grant, 4'b0001);
      chk("t2_burst_beat", c_beat, k);
      tick();
    end
    settle();
    chk("t2_after_burst", bus.c_grant, 4'b0010);
    chk("t2_burst_no_err", c_err_len, 0);
    tick();
    cidle();
    settle();
    chk("t2b_ostd_0", ostd_cnt, 0);

    // ID 2 queued to slave 0 then slave 1; slave 1 answers first
    push(8'd2, 4'b0001, 8'd0, 1'b0);
    push(8'd2, 4'b0010, 8'd0, 1'b0);
    slv(1, 1'b1, 1'b1, 8'd2);
    settle();
    chk("t3_block", bus.c_grant, 0);
    tick();
    settle();
    chk("t3_block_hold", bus.c_grant, 0);
    chk("t3_ostd", ostd_cnt, 2);
    slv(0, 1'b1, 1'b1, 8'd2);
    settle();
    chk("t3_slv0", bus.c_grant, 4'b0001);
    tick();
    settle();
    chk("t3_slv1", bus.c_grant, 4'b0010);
    tick();
    cidle();
    settle();
    chk("t3_ostd_0", ostd_cnt, 0);

    // fill queue 3
    for (int k = 0; k < 3; k++) push(8'd3, 4'b1000, 8'd0, 1'b0);
    bus.a_id = 8'd3;
    settle();
    chk("t4_not_full", bus.a_full, 0);
    push(8'd3, 4'b1000, 8'd0, 1'b0);
    bus.a_id = 8'd3;
    settle();
    chk("t4_full", bus.a_full, 1);
    bus.a_id = 8'd0;
    settle();
    chk("t4_other_free", bus.a_full, 0);
    push(8'd0, 4'b0001, 8'd0, 1'b0);
    push(8'd3, 4'b1000, 8'd0, 1'b0);  // dropped: queue 3 full
    settle();
    chk("t4_ostd_drop", ostd_cnt, 5);
    // same-cycle pull and push on queue 0
    slv(0, 1'b1, 1'b1, 8'd0);
    bus.a_valid = 1'b1; bus.a_id = 8'd0; bus.a_ix = 4'b0001; bus.a_len = 8'd0; bus.a_mr = 1'b0;
    settle();
    chk("t4_pp_grant", bus.c_grant, 4'b0001);
    tick();
    bus.a_valid = 1'b0;
    settle();
    chk("t4_pp_cnt", ostd_cnt, 5);
    chk("t4_pp_head", bus.c_grant, 4'b0001);
    tick();
    cidle();
    settle();
    chk("t4_ostd_4", ostd_cnt, 4);
    // drain queue 3; a_full drops the cycle after the first pull
    slv(3, 1'b1, 1'b1, 8'd3);
    bus.a_id = 8'd3;
    settle();
    chk("t4_full_at_pull", bus.a_full, 1);
    tick();
    settle();
    chk("t4_full_release", bus.a_full, 0);
    repeat (3) tick();
    settle();
    chk("t4_drained", bus.c_grant, 0);
    chk("t4_ostd_0", ostd_cnt, 0);
    cidle();

    // read length check: last on beat 0 with len 1
    push(8'd1, 4'b0100, 8'd1, 1'b0);
    slv(2, 1'b1, 1'b1, 8'd1);
    settle();
    chk("t5_grant", bus.c_grant, 4'b0100);
    chk("t5_err_before", c_err_len, 0);
    tick();
    cidle();
    settle();
    chk("t5_err_short", c_err_len, 1);
    chk("t5_pulled", ostd_cnt, 0);
    tick();
    settle();
    chk("t5_err_pulse", c_err_len, 0);
    // len 0 but two beats: both beats are flagged
    push(8'd1, 4'b0100, 8'd0, 1'b0);
    slv(2, 1'b1, 1'b0, 8'd1);
    tick();
    settle();
    chk("t5_err_long", c_err_len, 1);
    chk("t5_beat1", c_beat, 1);
    slv(2, 1'b1, 1'b1, 8'd1);
    tick();
    cidle();
    settle();
    chk("t5_err_last", c_err_len, 1);
    chk("t5_beat_clr", c_beat, 0);
    chk("t5_ostd_0", ostd_cnt, 0);
    tick();
    settle();
    chk("t5_err_done", c_err_len, 0);
    // misrouted head completes with no slave valid
    push(8'd2, 4'b0000, 8'd0, 1'b1);
    settle();
    chk("t5_mr", bus.c_mr, 1);
    chk("t5_mr_id", bus.c_id, 2);
    chk("t5_mr_grant", bus.c_grant, 0);
    tick();
    settle();
    chk("t5_mr_pulled", ostd_cnt, 0);
    chk("t5_mr_no_err", c_err_len, 0);
    chk("t5_mr_clr", bus.c_mr, 0);

    // sync reset flushes queues
    push(8'd0, 4'b0001, 8'd0, 1'b0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    settle();
    chk("t6_srst_ostd", ostd_cnt, 0);
    chk("t6_srst_timeout", c_timeout, 0);
    slv(0, 1'b1, 1'b1, 8'd0);
    settle();
    chk("t6_flushed", bus.c_grant, 0);
    cidle();
    // watchdog
    push(8'd0, 4'b0001, 8'd0, 1'b0);
    repeat (10) tick();
    settle();
    chk("t6_wd_early", c_timeout, 0);
    repeat (6) tick();
    settle();
    chk("t6_wd_fire", c_timeout, 1);
    repeat (5) tick();
    settle();
    chk("t6_wd_sticky", c_timeout, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    settle();
    chk("t6_wd_clr", c_timeout, 0);
    chk("t6_wd_ostd", ostd_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
